io_uart_device: RTL and testbench
=================================

# io_uart_device

Memory-mapped serial peripheral that sits on the device side of the CPU's I/O port handshake. It consumes the CPU-side `start`/`clear` strobes and store data, and serialises stored bytes onto a UART TX line. It deserialises the UART RX line into a held receive byte and reports `ready`/`busy` status back to the CPU-side I/O decoder. Placed at the top level between the CPU I/O decode logic and the board UART pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `WORD`, default 32: CPU data width.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle store strobe from the CPU side; requests transmission of `data_in[7:0]`.
- `data_in`  in  WORD  store data; only bits [7:0] are used.
- `clear`  in  1  one-cycle load-acknowledge strobe; consumes the held RX byte.
- `busy`  out  1  transmitter occupied.
- `ready`  out  1  RX byte held and unread.
- `r_data`  out  WORD  `{24'b0, rx_byte}`, valid while `ready`.
- `overrun`  out  1  sticky: a byte arrived while `ready` was already 1.
- `tx`  out  1  UART transmit line, idle high.
- `rx`  in  1  UART receive line, asynchronous to `clk`.

## Operation
- Reset values: `busy=0`, `ready=0`, `overrun=0`, `r_data=0`, `tx=1`. Both FSMs are forced to IDLE. Reset asserted mid-frame aborts the frame immediately with no partial output.
- Frame format: 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).
- TX FSM states:
  - IDLE: `tx=1`. On `start`, latch `data_in[7:0]` and go to START.
  - START: `tx=0` for one bit time.
  - DATA: shift out 8 bits, one per bit time, using a 3-bit index.
  - STOP: `tx=1` for one bit time, then IDLE.
- `busy` is 1 in every TX state except IDLE.
- `start` while `busy=1` is ignored. The shift register and line are unaffected.
- RX input: `rx` passes through a 2-flop synchroniser.
- RX FSM states:
  - IDLE: a synchronised falling edge goes to START.
  - START: resample after `CLKS_PER_BIT/2` cycles. If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits at bit centres, i.e. every `CLKS_PER_BIT` cycles.
  - STOP: sample at the centre of the stop bit. If 1, commit the byte. If 0 (framing error), discard the byte and return to IDLE with no status change.
- Commit: `rx_byte` ← shifted byte, `ready` ← 1.
  - If `ready` was already 1 and `clear` is not asserted that cycle, `overrun` ← 1 and the new byte overwrites the old one.
- `clear` sets `ready` to 0 and `overrun` to 0. `r_data` retains its last value.
- `clear` in the same cycle as a commit: the commit wins. `ready=1`, the new byte is held, and `overrun` is 0.
- `clear` while `ready=0` has no effect.
- TX and RX are fully independent. Simultaneous `start`, `clear` and an RX commit are all honoured.

## Timing
- `start` sampled at edge 0: `busy=1` and `tx=0` from edge 1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- `busy` returns to 0 at edge `1 + 10*CLKS_PER_BIT`.
- A `start` in that same cycle is accepted with no idle gap.
- RX: `ready` rises at the edge after the stop-bit centre sample. This is roughly `2 + 9.5*CLKS_PER_BIT` cycles after the start-bit falling edge on the pin, with the 2 cycles coming from the synchroniser.
- `clear` takes effect at the next edge.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure
- Shared package `io_pkg`:
  - TX/RX state enum (IDLE, START, DATA, STOP).
  - Default `CLKS_PER_BIT`.
  - Status bit positions: bit1 = ready, bit0 = ~busy. These match the CPU-side status word.
- One sub-module, `uart_bit_timer`. It is a cycle counter with a `load_half`/`load_full` input and a `tick` output, instantiated once for TX and once for RX.
- Top level holds the two FSMs, the shift registers, the synchroniser and the status flags.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- **Reset mid-TX:** `start` with `data_in=0x55`, assert `rst` at cycle 10 → `tx=1`, `busy=0` immediately. Next `start` sends a clean full frame.
- **TX frame:** `start` with `data_in=0xFFFF_FFA5` → `tx` sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles each. `busy` high for exactly 40 cycles. A `start` at cycle 20 is ignored.
- **RX byte:** drive frame 0x3C on `rx` → `ready=1`, `r_data=0x0000_003C`, `overrun=0`. `clear` → `ready=0`, `r_data` still `0x3C`.
- **Overrun:** two frames 0x11 then 0x22 without `clear` → `r_data=0x22`, `ready=1`, `overrun=1`. `clear` → both flags 0.
- **Framing error and glitch:** frame 0x7E with stop bit 0 → `ready` stays 0. A 1-cycle low pulse on `rx` → no frame started.
- **Simultaneous events:** `clear` on the commit cycle of byte 0x99 while a TX `start` is also asserted → `ready=1`, `r_data=0x99`, `overrun=0`, TX frame proceeds normally.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped UART device: FSM state encoding,
// default bit timing and the CPU-side status word layout.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam int STAT_READY_BIT = 1;
  localparam int STAT_NBUSY_BIT = 0;

  // Packs the flags the way the CPU-side decoder expects its status word.
  function automatic logic [1:0] status_bits(input logic busy, input logic ready);
    status_bits = '0;
    status_bits[STAT_READY_BIT] = ready;
    status_bits[STAT_NBUSY_BIT] = ~busy;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit-period timer. A load starts a full or half bit period and
// tick_o marks its last cycle, so the owning FSM advances on the following edge.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_full_i) begin
      count_d = CNT_W'(CLKS_PER_BIT - 1);
    end else if (load_half_i) begin
      count_d = CNT_W'(CLKS_PER_BIT / 2 - 1);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/io_uart_device.sv
// Device side of the CPU I/O handshake: serialises stored bytes onto tx (8N1)
// and holds bytes received on rx with ready/overrun status for the CPU.
module io_uart_device
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WORD         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] data_in,
  input  logic            clear,
  output logic            busy,
  output logic            ready,
  output logic [WORD-1:0] r_data,
  output logic            overrun,
  output logic            tx,
  input  logic            rx
);

  uart_state_e txState_q, txState_d;
  logic [7:0]  txShift_q, txShift_d;
  logic [2:0]  txIdx_q, txIdx_d;
  logic        txLine_q, txLine_d;
  logic        txBusy_q;
  logic        txLoad, txTick;

  uart_state_e rxState_q, rxState_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [2:0]  rxIdx_q, rxIdx_d;
  logic        rxMeta_q, rxSync_q, rxPrev_q;
  logic        rxLoadHalf, rxLoadFull, rxTick, rxCommit;

  logic [7:0]  rxByte_q, rxByte_d;
  logic        ready_q, ready_d, overrun_q, overrun_d;

  logic        unusedDataBits;
  assign unusedDataBits = ^data_in[WORD-1:8];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) txTimer (
    .clk(clk), .rst(rst), .load_half_i(1'b0), .load_full_i(txLoad), .tick_o(txTick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxTimer (
    .clk(clk), .rst(rst), .load_half_i(rxLoadHalf), .load_full_i(rxLoadFull), .tick_o(rxTick)
  );

  // tx is registered alongside the state so the line changes on the transition edge.
  always_comb begin
    txState_d = txState_q;
    txShift_d = txShift_q;
    txIdx_d   = txIdx_q;
    txLine_d  = txLine_q;
    txLoad    = 1'b0;
    unique case (txState_q)
      IDLE: if (start) begin
        txShift_d = data_in[7:0];
        txLine_d  = 1'b0;
        txLoad    = 1'b1;
        txState_d = START;
      end
      START: if (txTick) begin
        txIdx_d   = 3'd0;
        txLine_d  = txShift_q[0];
        txLoad    = 1'b1;
        txState_d = DATA;
      end
      DATA: if (txTick) begin
        txLoad = 1'b1;
        if (txIdx_q == 3'd7) begin
          txLine_d  = 1'b1;
          txState_d = STOP;
        end else begin
          txIdx_d   = txIdx_q + 3'd1;
          txShift_d = txShift_q >> 1;
          txLine_d  = txShift_q[1];
        end
      end
      STOP: if (txTick) begin
        // A store landing on the final stop-bit cycle chains straight into the next frame.
        if (start) begin
          txShift_d = data_in[7:0];
          txLine_d  = 1'b0;
          txLoad    = 1'b1;
          txState_d = START;
        end else begin
          txLine_d  = 1'b1;
          txState_d = IDLE;
        end
      end
      default: txState_d = IDLE;
    endcase
  end

  always_comb begin
    rxState_d  = rxState_q;
    rxShift_d  = rxShift_q;
    rxIdx_d    = rxIdx_q;
    rxLoadHalf = 1'b0;
    rxLoadFull = 1'b0;
    rxCommit   = 1'b0;
    unique case (rxState_q)
      IDLE: if (rxPrev_q && !rxSync_q) begin
        rxLoadHalf = 1'b1;
        rxState_d  = START;
      end
      START: if (rxTick) begin
        if (rxSync_q) begin
          rxState_d = IDLE;
        end else begin
          rxIdx_d    = 3'd0;
          rxLoadFull = 1'b1;
          rxState_d  = DATA;
        end
      end
      DATA: if (rxTick) begin
        rxShift_d  = {rxSync_q, rxShift_q[7:1]};
        rxLoadFull = 1'b1;
        if (rxIdx_q == 3'd7) begin
          rxState_d = STOP;
        end else begin
          rxIdx_d = rxIdx_q + 3'd1;
        end
      end
      STOP: if (rxTick) begin
        rxCommit  = rxSync_q;
        rxState_d = IDLE;
      end
      default: rxState_d = IDLE;
    endcase
  end

  // A commit beats a simultaneous clear; overrun only latches if the old byte was never read.
  always_comb begin
    rxByte_d  = rxByte_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (rxCommit) begin
      rxByte_d  = rxShift_q;
      ready_d   = 1'b1;
      overrun_d = clear ? 1'b0 : (overrun_q | ready_q);
    end else if (clear) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q <= IDLE;
      txShift_q <= '0;
      txIdx_q   <= '0;
      txLine_q  <= 1'b1;
      txBusy_q  <= 1'b0;
      rxState_q <= IDLE;
      rxShift_q <= '0;
      rxIdx_q   <= '0;
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxByte_q  <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txShift_q <= txShift_d;
      txIdx_q   <= txIdx_d;
      txLine_q  <= txLine_d;
      txBusy_q  <= (txState_d != IDLE);
      rxState_q <= rxState_d;
      rxShift_q <= rxShift_d;
      rxIdx_q   <= rxIdx_d;
      rxMeta_q  <= rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxByte_q  <= rxByte_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = txBusy_q;
  assign tx      = txLine_q;
  assign ready   = ready_q;
  assign overrun = overrun_q;
  assign r_data  = {{(WORD-8){1'b0}}, rxByte_q};

endmodule

// File: tb/tb_io_uart_device.sv
// Directed self-checking bench for io_uart_device at four clocks per bit;
// inputs change and outputs are sampled on the falling clock edge.
module tb_io_uart_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        clear;
  logic        busy;
  logic        ready;
  logic [31:0] r_data;
  logic        overrun;
  logic        tx;
  logic        rx;

  int checkCount = 0;
  int passCount  = 0;

  io_uart_device #(.CLKS_PER_BIT(4), .WORD(32)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .clear(clear),
    .busy(busy), .ready(ready), .r_data(r_data), .overrun(overrun),
    .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Caller sits on a falling edge; each bit is held for four clocks.
  task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = frame[k];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", ready); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passCount++;
    checkCount++; if (r_data !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", r_data); else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_tx_frame(input logic [7:0] b, input bit injectIgnored);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    start   = 1'b1;
    data_in = {24'hFFFFFF, b};
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (injectIgnored && i == 20) begin start = 1'b1; data_in = 32'h0; end
      if (injectIgnored && i == 21) start = 1'b0;
      if (i >= 2 && i <= 38 && ((i - 2) % 4) == 0) begin
        checkCount++;
        if (tx !== frame[(i - 2) / 4])
          $display("[TB] FAIL tx_bit%0d_%h: got %b expected %b", (i - 2) / 4, b, tx, frame[(i - 2) / 4]);
        else passCount++;
      end
      if (i == 40) begin
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL tx_busy_last: got %b expected 1", busy); else passCount++;
      end
      if (i == 41 || i == 45) begin
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL tx_busy_end%0d: got %b expected 0", i, busy); else passCount++;
      end
      if (i == 45) begin
        checkCount++; if (tx !== 1'b1) $display("[TB] FAIL tx_idle_line: got %b expected 1", tx); else passCount++;
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    @(negedge clk);
    start   = 1'b1;
    data_in = 32'h0000_0055;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) begin
        checkCount++; if (tx !== 1'b0) $display("[TB] FAIL midtx_startbit: got %b expected 0", tx); else passCount++;
      end
    end
    rst = 1'b1;
    #1;
    checkCount++; if (tx !== 1'b1) $display("[TB] FAIL midtx_reset_tx: got %b expected 1", tx); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midtx_reset_busy: got %b expected 0", busy); else passCount++;
    @(negedge clk);
    rst = 1'b0;
    test_tx_frame(8'h55, 1'b0);
  endtask

  task automatic test_rx_byte();
    int waitCycles;
    @(negedge clk);
    driveRxFrame(8'h3C, 1'b1);
    waitCycles = 0;
    while (ready !== 1'b1 && waitCycles < 8) begin @(negedge clk); waitCycles++; end
    checkCount++; if (ready !== 1'b1) $display("[TB] FAIL rx_ready: got %b expected 1", ready); else passCount++;
    checkCount++; if (r_data !== 32'h0000_003C) $display("[TB] FAIL rx_rdata: got %h expected 0000003c", r_data); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL rx_overrun: got %b expected 0", overrun); else passCount++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkCount++; if (ready !== 1'b0) $display("[TB] FAIL rx_clear_ready: got %b expected 0", ready); else passCount++;
    checkCount++; if (r_data !== 32'h0000_003C) $display("[TB] FAIL rx_clear_rdata: got %h expected 0000003c", r_data); else passCount++;
  endtask

  task automatic test_overrun();
    @(negedge clk);
    driveRxFrame(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    driveRxFrame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    checkCount++; if (r_data !== 32'h0000_0022) $display("[TB] FAIL ovr_rdata: got %h expected 00000022", r_data); else passCount++;
    checkCount++; if (ready !== 1'b1) $display("[TB] FAIL ovr_ready: got %b expected 1", ready); else passCount++;
    checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); else passCount++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkCount++; if (ready !== 1'b0) $display("[TB] FAIL ovr_clear_ready: got %b expected 0", ready); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_clear_flag: got %b expected 0", overrun); else passCount++;
  endtask

  task automatic test_framing_glitch();
    @(negedge clk);
    driveRxFrame(8'h7E, 1'b0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    checkCount++; if (ready !== 1'b0) $display("[TB] FAIL frame_err_ready: got %b expected 0", ready); else passCount++;
    checkCount++; if (r_data !== 32'h0000_0022) $display("[TB] FAIL frame_err_rdata: got %h expected 00000022", r_data); else passCount++;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    checkCount++; if (ready !== 1'b0) $display("[TB] FAIL glitch_ready: got %b expected 0", ready); else passCount++;
    checkCount++; if (r_data !== 32'h0000_0022) $display("[TB] FAIL glitch_rdata: got %h expected 00000022", r_data); else passCount++;
  endtask

  task automatic test_simultaneous();
    logic [9:0] frame;
    frame = {1'b1, 8'hC3, 1'b0};
    @(negedge clk);
    driveRxFrame(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    checkCount++; if (ready !== 1'b1) $display("[TB] FAIL sim_pre_ready: got %b expected 1", ready); else passCount++;
    driveRxFrame(8'h99, 1'b1);
    clear   = 1'b1;
    start   = 1'b1;
    data_in = 32'h0000_00C3;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (i == 1) begin
        clear = 1'b0;
        start = 1'b0;
        checkCount++; if (ready !== 1'b1) $display("[TB] FAIL sim_ready: got %b expected 1", ready); else passCount++;
        checkCount++; if (r_data !== 32'h0000_0099) $display("[TB] FAIL sim_rdata: got %h expected 00000099", r_data); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL sim_overrun: got %b expected 0", overrun); else passCount++;
      end
      if (i >= 2 && i <= 38 && ((i - 2) % 4) == 0) begin
        checkCount++;
        if (tx !== frame[(i - 2) / 4])
          $display("[TB] FAIL sim_tx_bit%0d: got %b expected %b", (i - 2) / 4, tx, frame[(i - 2) / 4]);
        else passCount++;
      end
      if (i == 40) begin
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL sim_busy_last: got %b expected 1", busy); else passCount++;
      end
      if (i == 41) begin
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL sim_busy_end: got %b expected 0", busy); else passCount++;
      end
    end
  endtask

  initial begin
    start   = 1'b0;
    clear   = 1'b0;
    data_in = 32'h0;
    rx      = 1'b1;
    $display("[TB] io_uart_device directed bench, CLKS_PER_BIT=4");
    test_reset();
    test_reset_mid_tx();
    test_tx_frame(8'hA5, 1'b1);
    test_rx_byte();
    test_overrun();
    test_framing_glitch();
    test_simultaneous();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
